// File: rtl/score_display_mux.sv
// Four-digit multiplexed 7-segment score display: two players, two BCD digits each.
// Digits are latched into a shadow once per full scan so a refresh never mixes old and new values.
module score_display_mux #(
   parameter int REFRESH_DIV = 100000,
   parameter int FLASH_DIV   = 25000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] p1_dig0,
   input  logic [3:0] p1_dig1,
   input  logic [3:0] p2_dig0,
   input  logic [3:0] p2_dig1,
   input  logic       blank_lz,
   input  logic       flash,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam int FW = $clog2(FLASH_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
   localparam logic [FW-1:0] FCNT_MAX  = FW'(FLASH_DIV - 1);

   typedef enum logic [1:0] {SLOT0 = 2'd0, SLOT1 = 2'd1, SLOT2 = 2'd2, SLOT3 = 2'd3} slot_t;

   logic [PW-1:0] presc_q, presc_d;
   slot_t         slot_q, slot_d;
   logic [15:0]   shadow_q, shadow_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          fphase_q, fphase_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;

   logic          presc_wrap;
   logic          fcnt_wrap;
   logic [3:0]    digit;

   // Active-low {g,f,e,d,c,b,a}; non-BCD values show a dash.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = 7'b0111111;
      endcase
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q  <= '0;
         slot_q   <= SLOT0;
         shadow_q <= '0;
         fcnt_q   <= '0;
         fphase_q <= 1'b0;
         an_q     <= '1;
         seg_q    <= '1;
         dp_q     <= 1'b1;
      end else begin
         presc_q  <= presc_d;
         slot_q   <= slot_d;
         shadow_q <= shadow_d;
         fcnt_q   <= fcnt_d;
         fphase_q <= fphase_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
      end
   end

   always_comb begin
      presc_wrap = (presc_q == PRESC_MAX);
      presc_d    = presc_wrap ? '0 : presc_q + 1'b1;

      slot_d = slot_q;
      if (presc_wrap) begin
         case (slot_q)
            SLOT0:   slot_d = SLOT1;
            SLOT1:   slot_d = SLOT2;
            SLOT2:   slot_d = SLOT3;
            default: slot_d = SLOT0;
         endcase
      end

      shadow_d = shadow_q;
      if (presc_q == '0 && slot_q == SLOT0)
         shadow_d = {p1_dig1, p1_dig0, p2_dig1, p2_dig0};

      fcnt_wrap = (fcnt_q == FCNT_MAX);
      fcnt_d    = fcnt_wrap ? '0 : fcnt_q + 1'b1;
      fphase_d  = fphase_q ^ fcnt_wrap;

      case (slot_q)
         SLOT0:   begin digit = shadow_q[3:0];   an_d = 4'b1110; end
         SLOT1:   begin digit = shadow_q[7:4];   an_d = 4'b1101; end
         SLOT2:   begin digit = shadow_q[11:8];  an_d = 4'b1011; end
         default: begin digit = shadow_q[15:12]; an_d = 4'b0111; end
      endcase

      seg_d = seg7(digit);
      // Only tens slots are candidates for leading-zero blanking; the anode stays on.
      if ((slot_q == SLOT1 || slot_q == SLOT3) && blank_lz && digit == 4'd0)
         seg_d = '1;
      dp_d = (slot_q != SLOT2);

      if (flash && fphase_q) begin
         an_d  = '1;
         seg_d = '1;
         dp_d  = 1'b1;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_score_display_mux.sv
// Directed bench for score_display_mux with REFRESH_DIV=4, FLASH_DIV=8.
// Table of score vectors checked across a full scan, plus flash, mid-scan update and async reset sequences.
module tb_score_display_mux;

   localparam logic [6:0] S0    = 7'b1000000;
   localparam logic [6:0] S1    = 7'b1111001;
   localparam logic [6:0] S2    = 7'b0100100;
   localparam logic [6:0] S3    = 7'b0110000;
   localparam logic [6:0] S4    = 7'b0011001;
   localparam logic [6:0] S5    = 7'b0010010;
   localparam logic [6:0] S6    = 7'b0000010;
   localparam logic [6:0] S7    = 7'b1111000;
   localparam logic [6:0] S8    = 7'b0000000;
   localparam logic [6:0] S9    = 7'b0010000;
   localparam logic [6:0] SDASH = 7'b0111111;
   localparam logic [6:0] SOFF  = 7'b1111111;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] p1_dig0 = '0, p1_dig1 = '0, p2_dig0 = '0, p2_dig1 = '0;
   logic       blank_lz = 1'b0;
   logic       flash = 1'b0;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   int checks = 0;
   int errors = 0;

   score_display_mux #(.REFRESH_DIV(4), .FLASH_DIV(8)) dut (
      .clk(clk), .reset(reset),
      .p1_dig0(p1_dig0), .p1_dig1(p1_dig1), .p2_dig0(p2_dig0), .p2_dig1(p2_dig1),
      .blank_lz(blank_lz), .flash(flash),
      .an(an), .seg(seg), .dp(dp)
   );

   always #5 clk = ~clk;

   // exp_seg is packed [slot3, slot2, slot1, slot0]
   typedef struct {
      logic [3:0]      p1d1, p1d0, p2d1, p2d0;
      logic            blz;
      logic [3:0][6:0] exp_seg;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [3:0] ea, input logic [6:0] es, input logic ed);
      checks++;
      if ({an, seg, dp} !== {ea, es, ed}) begin
         errors++;
         $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                  name, an, seg, dp, ea, es, ed);
      end
   endtask

   function automatic logic [3:0] an_of(input int s);
      logic [3:0] a;
      a = 4'b1111;
      a[s] = 1'b0;
      return a;
   endfunction

   task automatic apply(input vec_t v);
      p1_dig1 = v.p1d1; p1_dig0 = v.p1d0; p2_dig1 = v.p2d1; p2_dig0 = v.p2d0;
      blank_lz = v.blz;
   endtask

   // Reset released on a falling edge so the next rising edge is edge 1.
   task automatic do_reset(input string tag);
      @(negedge clk) reset = 1'b1;
      #1 check({tag, "_in_reset"}, 4'b1111, SOFF, 1'b1);
      @(negedge clk) reset = 1'b0;
   endtask

   task automatic run_edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{4'd1, 4'd2, 4'd3, 4'd4, 1'b0, {S1, S2, S3, S4}};
      vecs[1] = '{4'd0, 4'd0, 4'd5, 4'd6, 1'b1, {SOFF, S0, S5, S6}};
      vecs[2] = '{4'd0, 4'd9, 4'd0, 4'd8, 1'b0, {S0, S9, S0, S8}};
      vecs[3] = '{4'd7, 4'hF, 4'hA, 4'hC, 1'b1, {S7, SDASH, SDASH, SDASH}};
      vecs[4] = '{4'd0, 4'd1, 4'd0, 4'd0, 1'b1, {SOFF, S1, SOFF, S0}};

      repeat (2) @(posedge clk);
      #1 check("power_on_reset", 4'b1111, SOFF, 1'b1);

      for (int i = 0; i < 5; i++) begin
         apply(vecs[i]);
         do_reset($sformatf("v%0d", i));
         run_edges(1);
         check($sformatf("v%0d_stale", i), 4'b1110, S0, 1'b1);
         run_edges(1);
         check($sformatf("v%0d_slot0", i), 4'b1110, vecs[i].exp_seg[0], 1'b1);
         run_edges(4);
         check($sformatf("v%0d_slot1", i), 4'b1101, vecs[i].exp_seg[1], 1'b1);
         run_edges(4);
         check($sformatf("v%0d_slot2", i), 4'b1011, vecs[i].exp_seg[2], 1'b0);
         run_edges(4);
         check($sformatf("v%0d_slot3", i), 4'b0111, vecs[i].exp_seg[3], 1'b1);
      end

      // Digit change mid-scan must wait for the next slot0 shadow load.
      apply(vecs[0]);
      do_reset("mid");
      run_edges(6);
      check("mid_slot1", 4'b1101, S3, 1'b1);
      p2_dig0 = 4'd7;
      run_edges(4);
      check("mid_slot2_unchanged", 4'b1011, S2, 1'b0);
      run_edges(4);
      check("mid_slot3_unchanged", 4'b0111, S1, 1'b1);
      run_edges(3);
      check("mid_next_slot0_old", 4'b1110, S4, 1'b1);
      run_edges(1);
      check("mid_next_slot0_new", 4'b1110, S7, 1'b1);

      // Flash: blank on edges 9..16 and 25..32; scan keeps running underneath.
      apply(vecs[0]);
      flash = 1'b1;
      do_reset("flash");
      for (int k = 1; k <= 30; k++) begin
         int s;
         logic [6:0] es;
         run_edges(1);
         s  = ((k - 1) / 4) % 4;
         es = (k == 1) ? S0 : vecs[0].exp_seg[s];
         if (((k - 1) / 8) % 2 == 1)
            check($sformatf("flash_e%0d", k), 4'b1111, SOFF, 1'b1);
         else
            check($sformatf("flash_e%0d", k), an_of(s), es, (s == 2) ? 1'b0 : 1'b1);
      end
      flash = 1'b0;
      run_edges(1);
      check("flash_release", 4'b0111, S1, 1'b1);
      run_edges(2);
      check("flash_after_slot0", 4'b1110, S4, 1'b1);

      // Asynchronous reset mid-slot2, then restart with a fresh shadow.
      apply(vecs[0]);
      do_reset("areset");
      run_edges(10);
      check("areset_slot2", 4'b1011, S2, 1'b0);
      #2 reset = 1'b1;
      #1 check("areset_immediate", 4'b1111, SOFF, 1'b1);
      apply(vecs[2]);
      @(posedge clk);
      #1 check("areset_held", 4'b1111, SOFF, 1'b1);
      @(negedge clk) reset = 1'b0;
      run_edges(1);
      check("areset_restart_stale", 4'b1110, S0, 1'b1);
      run_edges(1);
      check("areset_restart_fresh", 4'b1110, S8, 1'b1);
      run_edges(4);
      check("areset_restart_slot1", 4'b1101, S0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/score_display_mux.md
SCORE_DISPLAY_MUX -- requirements
Module: score_display_mux

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000: clock cycles per digit slot; legal range >= 2.
REQ-002 SHALL have parameter FLASH_DIV, default 25000000: clock cycles per flash phase; legal range >= 2.
REQ-003 SHALL have port clk, input, 1: system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have ports p1_dig0 and p1_dig1, input, 4 each: player-1 BCD ones and tens digits.
REQ-006 SHALL have ports p2_dig0 and p2_dig1, input, 4 each: player-2 BCD ones and tens digits.
REQ-007 SHALL have port blank_lz, input, 1: 1 blanks a tens digit whose value is 0.
REQ-008 SHALL have port flash, input, 1: 1 blinks the whole display at the FLASH_DIV rate (game over).
REQ-009 SHALL have port an, output, 4: active-low digit anodes; at most one bit low at any time.
REQ-010 SHALL have port seg, output, 7: active-low segments {g,f,e,d,c,b,a}.
REQ-011 SHALL have port dp, output, 1: active-low decimal point.

Function
REQ-012 SHALL run a prescaler counting 0..REFRESH_DIV-1 that wraps to 0.
REQ-013 SHALL advance the 2-bit slot register 0->1->2->3->0 on each prescaler wrap, and only then.
REQ-014 SHALL map slots to digits: slot0 an[0]=p2_dig0; slot1 an[1]=p2_dig1; slot2 an[2]=p1_dig0; slot3 an[3]=p1_dig1.
REQ-015 SHALL load a 16-bit shadow copy of all four digit inputs on every edge where prescaler==0 and slot==0, including the first edge after reset release.
REQ-016 SHALL leave the shadow unchanged at all other times, so no scan shows a mix of old and new digits.
REQ-017 SHALL register an, seg and dp from the current slot, shadow, blank_lz, flash and flash phase; outputs lag those inputs by 1 clock.
REQ-018 SHALL decode shadow digit values 0-9 to standard 7-segment patterns, e.g. 0=1000000, 1=1111001, 8=0000000, 9=0010000.
REQ-019 SHALL drive seg=0111111 (dash, g only) for any shadow digit value 10-15.
REQ-020 SHALL drive seg=1111111 for slot1 or slot3 when blank_lz=1 and that shadow tens digit==0; the anode is still driven low.
REQ-021 SHALL never blank a ones digit (slot0 or slot2), including when its value is 0.
REQ-022 SHALL drive dp=0 only in slot2 (player separator); dp=1 in all other slots.
REQ-023 SHALL run a free-running flash counter 0..FLASH_DIV-1 and toggle a flash_phase bit on each wrap, independent of the flash input.
REQ-024 SHALL drive an=1111, seg=1111111 and dp=1 while flash=1 and flash_phase=1.
REQ-025 SHALL resume normal display on the next registered update after flash deasserts, without resetting the scan.
REQ-026 SHALL continue prescaler, slot and shadow operation unchanged during flash blanking.

Reset
REQ-027 SHALL, on reset assertion and regardless of clk, set prescaler=0, slot=0, shadow=0, flash counter=0 and flash_phase=0.
REQ-028 SHALL, on reset assertion, set an=1111, seg=1111111 and dp=1.
REQ-029 SHALL hold all outputs at those values while reset is high.
REQ-030 SHALL, when reset asserts mid-scan or mid-flash, abandon the operation immediately and restart from slot0 with a fresh shadow load.

Verification (REFRESH_DIV=4, FLASH_DIV=8)
REQ-031 Reset release with p1=(dig1 1, dig0 2), p2=(dig1 3, dig0 4), blank_lz=0 -> edge1 an=1110 seg=1000000 (stale shadow 0); edge2 an=1110 seg=0011001 ("4"); an becomes 1101 with seg "3" 4 cycles later, then 1011 with "2" and dp=0, then 0111 with "1".
REQ-032 Change p2_dig0 4->7 mid-scan in slot1 -> slots 1-3 of the current scan are unchanged; "7" first appears at the next slot0.
REQ-033 p1_dig1=0, blank_lz=1 -> slot3 an=0111 seg=1111111; with blank_lz=0 -> slot3 seg=1000000; p1_dig0=0 with blank_lz=1 -> slot2 still shows "0".
REQ-034 p2_dig0=4'hC -> slot0 seg=0111111.
REQ-035 flash=1 held for 32 cycles -> an alternates between 1111 and a normal scan every 8 cycles; slot advance is uninterrupted; after flash=0 the next cycle shows the normal digit.
REQ-036 Assert reset for 1 cycle mid-slot2 -> outputs go to all-ones immediately (asynchronously); after release the scan restarts at slot0 with a fresh shadow.
